// File: rtl/nco_sweep_controller.sv
// nco_sweep_controller
//   Steps the NCO phase increment from a stored start value to a stored stop
//   value in signed steps, holding each value for a programmable dwell.
//   Config (start/stop/step/dwell) is loaded by a valid/ready handshake
//   while idle.
//   Optional build macro NCO_SWEEP_PINGPONG_EN: the sweep bounces between
//   start and stop until aborted, pulsing sweep_done each time it leaves the
//   start endpoint. Without the macro the sweep is one-shot and no
//   direction register exists.
module nco_sweep_controller #(
    parameter int unsigned INC_W   = 32,
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [INC_W-1:0]   cfg_start,
    input  logic [INC_W-1:0]   cfg_stop,
    input  logic [INC_W-1:0]   cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               start,
    input  logic               abort,
    output logic [INC_W-1:0]   phase_inc,
    output logic               busy,
    output logic               step_strobe,
    output logic               sweep_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        LAST  = 2'd2
    } state_t;

    state_t             state;
    logic [INC_W-1:0]   start_q;
    logic [INC_W-1:0]   stop_q;
    logic [INC_W-1:0]   step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] dwell_load;
    logic               cfg_fire;
    logic               expire;

    // Two guard bits: one keeps phase_inc+step from wrapping, the second
    // covers negating the most negative step in ping-pong mode.
    logic signed [INC_W+1:0] cur_x;
    logic signed [INC_W+1:0] step_x;
    logic signed [INC_W+1:0] target_x;
    logic signed [INC_W+1:0] nxt;
    logic                    clamp;

`ifdef NCO_SWEEP_PINGPONG_EN
    logic dir;
    logic dir_n;
`endif

    assign cfg_ready  = (state == IDLE);
    assign cfg_fire   = cfg_valid && cfg_ready;
    assign expire     = (dwell_cnt == '0);
    assign dwell_load = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);

    // Next candidate value and endpoint clamp decision for the active direction
    always_comb begin
        cur_x    = {{2{phase_inc[INC_W-1]}}, phase_inc};
        step_x   = {{2{step_q[INC_W-1]}}, step_q};
        target_x = {{2{stop_q[INC_W-1]}}, stop_q};
`ifdef NCO_SWEEP_PINGPONG_EN
        // In LAST the next move is the first one of the reversed leg.
        dir_n = (state == LAST) ? ~dir : dir;
        if (dir_n) begin
            step_x   = -step_x;
            target_x = {{2{start_q[INC_W-1]}}, start_q};
        end
`endif
        nxt   = cur_x + step_x;
        clamp = (step_x == '0) ||
                (!step_x[INC_W+1] && (nxt >= target_x)) ||
                ( step_x[INC_W+1] && (nxt <= target_x));
    end

    // Config capture and sweep sequencer with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            start_q     <= '0;
            stop_q      <= '0;
            step_q      <= '0;
            dwell_q     <= '0;
            dwell_cnt   <= '0;
            phase_inc   <= '0;
            busy        <= 1'b0;
            step_strobe <= 1'b0;
            sweep_done  <= 1'b0;
`ifdef NCO_SWEEP_PINGPONG_EN
            dir         <= 1'b0;
`endif
        end else begin
            step_strobe <= 1'b0;
            sweep_done  <= 1'b0;

            if (cfg_fire) begin
                start_q <= cfg_start;
                stop_q  <= cfg_stop;
                step_q  <= cfg_step;
                dwell_q <= cfg_dwell;
            end

            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !cfg_fire) begin
                            state       <= SWEEP;
                            busy        <= 1'b1;
                            phase_inc   <= start_q;
                            step_strobe <= 1'b1;
                            dwell_cnt   <= dwell_load;
`ifdef NCO_SWEEP_PINGPONG_EN
                            dir         <= 1'b0;
`endif
                        end
                    end

                    SWEEP: begin
                        if (expire) begin
                            step_strobe <= 1'b1;
                            dwell_cnt   <= dwell_load;
                            if (clamp) begin
                                phase_inc <= target_x[INC_W-1:0];
                                state     <= LAST;
                            end else begin
                                phase_inc <= nxt[INC_W-1:0];
                            end
                        end else begin
                            dwell_cnt <= dwell_cnt - DWELL_W'(1);
                        end
                    end

                    LAST: begin
                        if (expire) begin
`ifdef NCO_SWEEP_PINGPONG_EN
                            sweep_done  <= dir;
                            dir         <= ~dir;
                            step_strobe <= 1'b1;
                            dwell_cnt   <= dwell_load;
                            if (clamp) begin
                                phase_inc <= target_x[INC_W-1:0];
                                state     <= LAST;
                            end else begin
                                phase_inc <= nxt[INC_W-1:0];
                                state     <= SWEEP;
                            end
`else
                            sweep_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
`endif
                        end else begin
                            dwell_cnt <= dwell_cnt - DWELL_W'(1);
                        end
                    end

                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
